// File: rtl/cc_move_sequencer.sv
// Move/line-clear sequencer for the 8x8 falling-piece game: issues trial, commit,
// revert, merge, row-clear and spawn strobes to external piece/background logic.
module cc_move_sequencer #(
  parameter int ROWS          = 8,
  parameter int ROW_IDX_WIDTH = 3,
  parameter int LINES_WIDTH   = 8
) (
  input  logic                     CC_MOVE_SEQUENCER_CLOCK_50,
  input  logic                     CC_MOVE_SEQUENCER_RESET_InHigh,
  input  logic                     CC_MOVE_SEQUENCER_TICK_InHigh,
  input  logic                     CC_MOVE_SEQUENCER_LEFT_InHigh,
  input  logic                     CC_MOVE_SEQUENCER_RIGHT_InHigh,
  input  logic                     CC_MOVE_SEQUENCER_COLLISION_InLow,
  input  logic [ROWS-1:0]          CC_MOVE_SEQUENCER_ROWFULL_InBUS,
  output logic                     CC_MOVE_SEQUENCER_TRIAL_OutHigh,
  output logic [1:0]               CC_MOVE_SEQUENCER_DIR_OutBUS,
  output logic                     CC_MOVE_SEQUENCER_COMMIT_OutHigh,
  output logic                     CC_MOVE_SEQUENCER_REVERT_OutHigh,
  output logic                     CC_MOVE_SEQUENCER_MERGE_OutHigh,
  output logic                     CC_MOVE_SEQUENCER_CLEARROW_OutHigh,
  output logic [ROW_IDX_WIDTH-1:0] CC_MOVE_SEQUENCER_ROWIDX_OutBUS,
  output logic                     CC_MOVE_SEQUENCER_SPAWN_OutHigh,
  output logic                     CC_MOVE_SEQUENCER_BUSY_OutHigh,
  output logic                     CC_MOVE_SEQUENCER_GAMEOVER_OutHigh,
  output logic [LINES_WIDTH-1:0]   CC_MOVE_SEQUENCER_LINES_OutBUS
);

  typedef enum logic [3:0] {
    S_IDLE, S_TRIAL, S_CHECK, S_COMMIT, S_REVERT, S_MERGE,
    S_SCAN, S_CLEAR, S_SPAWN, S_SPAWN_CHK, S_GAMEOVER
  } state_t;

  localparam logic [1:0] DIR_DOWN  = 2'b00;
  localparam logic [1:0] DIR_LEFT  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [ROW_IDX_WIDTH-1:0] ROW_BOTTOM = ROW_IDX_WIDTH'(ROWS - 1);

  state_t                   r_state;
  logic [1:0]               r_dir;
  logic                     r_pending;
  logic [ROW_IDX_WIDTH-1:0] r_rowidx;
  logic [LINES_WIDTH-1:0]   r_lines;
  logic                     r_trial, r_commit, r_revert, r_merge;
  logic                     r_clear, r_spawn, r_busy, r_gameover;

  state_t     w_next;
  logic [1:0] w_dir;
  logic       w_row_full;
  logic       w_tick_req;

  assign w_row_full = CC_MOVE_SEQUENCER_ROWFULL_InBUS[r_rowidx];
  assign w_tick_req = CC_MOVE_SEQUENCER_TICK_InHigh | r_pending;

  always_comb begin
    w_next = r_state;
    w_dir  = r_dir;
    case (r_state)
      S_IDLE: begin
        if (w_tick_req) begin
          w_next = S_TRIAL;
          w_dir  = DIR_DOWN;
        end else if (CC_MOVE_SEQUENCER_LEFT_InHigh) begin
          w_next = S_TRIAL;
          w_dir  = DIR_LEFT;
        end else if (CC_MOVE_SEQUENCER_RIGHT_InHigh) begin
          w_next = S_TRIAL;
          w_dir  = DIR_RIGHT;
        end
      end
      S_TRIAL:     w_next = S_CHECK;
      S_CHECK:     w_next = CC_MOVE_SEQUENCER_COLLISION_InLow ? S_COMMIT : S_REVERT;
      S_COMMIT:    w_next = S_IDLE;
      S_REVERT:    w_next = (r_dir == DIR_DOWN) ? S_MERGE : S_IDLE;
      S_MERGE:     w_next = S_SCAN;
      // Bottom-up scan; a cleared row is re-examined since rows above drop into it.
      S_SCAN: begin
        if (w_row_full)          w_next = S_CLEAR;
        else if (r_rowidx == '0) w_next = S_SPAWN;
        else                     w_next = S_SCAN;
      end
      S_CLEAR:     w_next = S_SCAN;
      S_SPAWN:     w_next = S_SPAWN_CHK;
      S_SPAWN_CHK: w_next = CC_MOVE_SEQUENCER_COLLISION_InLow ? S_IDLE : S_GAMEOVER;
      S_GAMEOVER:  w_next = S_GAMEOVER;
      default:     w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CC_MOVE_SEQUENCER_CLOCK_50) begin
    if (CC_MOVE_SEQUENCER_RESET_InHigh) begin
      r_state    <= S_IDLE;
      r_dir      <= DIR_DOWN;
      r_pending  <= 1'b0;
      r_rowidx   <= ROW_BOTTOM;
      r_lines    <= '0;
      r_trial    <= 1'b0;
      r_commit   <= 1'b0;
      r_revert   <= 1'b0;
      r_merge    <= 1'b0;
      r_clear    <= 1'b0;
      r_spawn    <= 1'b0;
      r_busy     <= 1'b0;
      r_gameover <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_dir      <= w_dir;
      // Strobes are decoded from the next state so they line up with the state register.
      r_trial    <= (w_next == S_TRIAL);
      r_commit   <= (w_next == S_COMMIT);
      r_revert   <= (w_next == S_REVERT);
      r_merge    <= (w_next == S_MERGE);
      r_clear    <= (w_next == S_CLEAR);
      r_spawn    <= (w_next == S_SPAWN);
      r_busy     <= (w_next != S_IDLE);
      r_gameover <= (w_next == S_GAMEOVER);

      if (w_next == S_TRIAL && w_dir == DIR_DOWN)
        r_pending <= 1'b0;
      else if (CC_MOVE_SEQUENCER_TICK_InHigh && r_state != S_IDLE && r_state != S_GAMEOVER)
        r_pending <= 1'b1;

      if (r_state == S_MERGE)
        r_rowidx <= ROW_BOTTOM;
      else if (r_state == S_SCAN && !w_row_full && r_rowidx != '0)
        r_rowidx <= r_rowidx - 1'b1;

      if (r_state == S_CLEAR)
        r_lines <= r_lines + 1'b1;
    end
  end

  assign CC_MOVE_SEQUENCER_TRIAL_OutHigh    = r_trial;
  assign CC_MOVE_SEQUENCER_DIR_OutBUS       = r_dir;
  assign CC_MOVE_SEQUENCER_COMMIT_OutHigh   = r_commit;
  assign CC_MOVE_SEQUENCER_REVERT_OutHigh   = r_revert;
  assign CC_MOVE_SEQUENCER_MERGE_OutHigh    = r_merge;
  assign CC_MOVE_SEQUENCER_CLEARROW_OutHigh = r_clear;
  assign CC_MOVE_SEQUENCER_ROWIDX_OutBUS    = r_rowidx;
  assign CC_MOVE_SEQUENCER_SPAWN_OutHigh    = r_spawn;
  assign CC_MOVE_SEQUENCER_BUSY_OutHigh     = r_busy;
  assign CC_MOVE_SEQUENCER_GAMEOVER_OutHigh = r_gameover;
  assign CC_MOVE_SEQUENCER_LINES_OutBUS     = r_lines;

endmodule

// File: tb/tb_cc_move_sequencer.sv
// Directed bench for cc_move_sequencer: moves, line clears, pending tick, game over, reset.
module tb_cc_move_sequencer;

  logic       clk = 1'b0;
  logic       rst, tick, left, right, coll;
  logic [7:0] rowfull;
  logic       trial, commit, revert, merge, clearrow, spawn, busy, gameover;
  logic [1:0] dir;
  logic [2:0] rowidx;
  logic [7:0] lines;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cc_move_sequencer #(.ROWS(8), .ROW_IDX_WIDTH(3), .LINES_WIDTH(8)) dut (
    .CC_MOVE_SEQUENCER_CLOCK_50        (clk),
    .CC_MOVE_SEQUENCER_RESET_InHigh    (rst),
    .CC_MOVE_SEQUENCER_TICK_InHigh     (tick),
    .CC_MOVE_SEQUENCER_LEFT_InHigh     (left),
    .CC_MOVE_SEQUENCER_RIGHT_InHigh    (right),
    .CC_MOVE_SEQUENCER_COLLISION_InLow (coll),
    .CC_MOVE_SEQUENCER_ROWFULL_InBUS   (rowfull),
    .CC_MOVE_SEQUENCER_TRIAL_OutHigh   (trial),
    .CC_MOVE_SEQUENCER_DIR_OutBUS      (dir),
    .CC_MOVE_SEQUENCER_COMMIT_OutHigh  (commit),
    .CC_MOVE_SEQUENCER_REVERT_OutHigh  (revert),
    .CC_MOVE_SEQUENCER_MERGE_OutHigh   (merge),
    .CC_MOVE_SEQUENCER_CLEARROW_OutHigh(clearrow),
    .CC_MOVE_SEQUENCER_ROWIDX_OutBUS   (rowidx),
    .CC_MOVE_SEQUENCER_SPAWN_OutHigh   (spawn),
    .CC_MOVE_SEQUENCER_BUSY_OutHigh    (busy),
    .CC_MOVE_SEQUENCER_GAMEOVER_OutHigh(gameover),
    .CC_MOVE_SEQUENCER_LINES_OutBUS    (lines)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe vector {trial,commit,revert,merge,clearrow,spawn,busy,gameover}
  function automatic logic [31:0] strobes();
    return {24'd0, trial, commit, revert, merge, clearrow, spawn, busy, gameover};
  endfunction

  initial begin
    rst = 1'b1; tick = 1'b0; left = 1'b0; right = 1'b0; coll = 1'b1; rowfull = 8'h00;
    step();
    step();
    rst = 1'b0;
    chk("reset_strobes", strobes(), 32'h00);
    chk("reset_rowidx", rowidx, 7);
    chk("reset_lines", lines, 0);
    chk("reset_dir", dir, 0);

    // Free down move
    tick = 1'b1; coll = 1'b1;
    step(); tick = 1'b0;
    chk("down_trial", strobes(), 32'b1000_0010);
    chk("down_dir", dir, 2'b00);
    step();
    chk("down_check", strobes(), 32'b0000_0010);
    step();
    chk("down_commit", strobes(), 32'b0100_0010);
    step();
    chk("down_idle", strobes(), 32'h00);

    // Blocked left move
    left = 1'b1; coll = 1'b0;
    step(); left = 1'b0;
    chk("left_trial", strobes(), 32'b1000_0010);
    chk("left_dir", dir, 2'b01);
    step();
    step();
    chk("left_revert", strobes(), 32'b0010_0010);
    chk("left_revert_dir", dir, 2'b01);
    step();
    chk("left_idle", strobes(), 32'h00);
    chk("left_lines", lines, 0);

    // Simultaneous requests: only down is served
    tick = 1'b1; left = 1'b1; right = 1'b1; coll = 1'b1;
    step(); tick = 1'b0; left = 1'b0; right = 1'b0;
    chk("prio_trial", strobes(), 32'b1000_0010);
    chk("prio_dir", dir, 2'b00);
    step(); step();
    chk("prio_commit", strobes(), 32'b0100_0010);
    step();
    chk("prio_idle", strobes(), 32'h00);
    step();
    chk("prio_no_second", strobes(), 32'h00);

    // Blocked down with two full bottom rows, plus a tick during the scan
    tick = 1'b1; coll = 1'b0; rowfull = 8'hC0;
    step(); tick = 1'b0;
    step();
    step();
    chk("land_revert", strobes(), 32'b0010_0010);
    coll = 1'b1;
    step();
    chk("land_merge", strobes(), 32'b0001_0010);
    step();
    chk("land_scan7", strobes(), 32'b0000_0010);
    chk("land_scan7_idx", rowidx, 7);
    step();
    chk("clear1", strobes(), 32'b0000_1010);
    chk("clear1_idx", rowidx, 7);
    rowfull = 8'h80;
    step();
    chk("rescan_idx", rowidx, 7);
    chk("lines_after1", lines, 1);
    step();
    chk("clear2", strobes(), 32'b0000_1010);
    chk("clear2_idx", rowidx, 7);
    rowfull = 8'h00;
    step();
    chk("lines_after2", lines, 2);
    for (int i = 7; i >= 0; i--) begin
      chk("scan_idx", rowidx, i);
      chk("scan_strobes", strobes(), 32'b0000_0010);
      if (i == 7) tick = 1'b1;
      step();
      tick = 1'b0;
    end
    chk("spawn", strobes(), 32'b0000_0110);
    step();
    chk("spawn_chk", strobes(), 32'b0000_0010);
    step();
    chk("post_spawn_idle", strobes(), 32'h00);
    chk("post_spawn_lines", lines, 2);
    step();
    chk("pending_trial", strobes(), 32'b1000_0010);
    chk("pending_dir", dir, 2'b00);
    step(); step();
    chk("pending_commit", strobes(), 32'b0100_0010);
    step(); step();
    chk("pending_cleared", strobes(), 32'h00);

    // Landing with spawn collision -> game over
    tick = 1'b1; coll = 1'b0; rowfull = 8'h00;
    step(); tick = 1'b0;
    step(); step(); step(); step();
    chk("go_scan_start", rowidx, 7);
    for (int i = 0; i < 8; i++) step();
    chk("go_spawn", strobes(), 32'b0000_0110);
    step(); step();
    chk("go_state", strobes(), 32'b0000_0011);
    for (int i = 0; i < 20; i++) begin
      tick = i[0]; left = ~i[0];
      step();
      chk("go_hold", strobes(), 32'b0000_0011);
    end
    tick = 1'b0; left = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("go_reset", strobes(), 32'h00);
    chk("go_reset_lines", lines, 0);

    // Reset in the middle of a scan
    tick = 1'b1; coll = 1'b0; rowfull = 8'h80;
    step(); tick = 1'b0;
    step(); step(); step(); step();
    step();
    chk("mid_clear", strobes(), 32'b0000_1010);
    rowfull = 8'h00; coll = 1'b1;
    step();
    chk("mid_lines", lines, 1);
    step();
    chk("mid_scan6", rowidx, 6);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_strobes", strobes(), 32'h00);
    chk("mid_rst_lines", lines, 0);
    chk("mid_rst_idx", rowidx, 7);
    step();
    chk("mid_rst_stay_idle", strobes(), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
